// File: rtl/bus_coherence_ctrl.sv
// bus_coherence_ctrl: two-core snooping coherence controller sharing one RAM port.
// Ports:
//   CLK, nRST           clock, asynchronous active-low reset
//   dREN/dWEN/cctrans/ccwrite/daddr/dstore [c]  dcache requests and snoop acks per core
//   dwait/dload/ccwait/ccinv/ccsnoopaddr [c]    stall, read data, snoop request, grant/invalidate, snoop address
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ram_ack  shared RAM port
// Macro SNOOP_FORWARD_EN: when defined, a dirty peer's writeback data is forwarded
// straight to the reading core and the RAM reload (LD1/LD2) is skipped.
module bus_coherence_ctrl (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ram_ack
);
  typedef enum logic [3:0] {IDLE, ARB, SNOOP, PEERWB1, PEERWB2, LD1, LD2, UPG, DWB} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d;
  logic last_q, last_d, r_q, r_d, upg_q, upg_d, wr_q, wr_d;
  logic [1:0] rd, up, wb, req;
  logic p, pick;
  assign rd   = cctrans & dREN;
  assign up   = cctrans & ccwrite & ~dREN & ~dWEN;
  assign wb   = dWEN & ~cctrans;
  assign req  = rd | up | wb;
  assign p    = ~r_q;
  // last_q names the core favoured on the next tie; it flips to the other core once a transaction completes
  assign pick = (req[0] & req[1]) ? last_q : req[1];
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      a_q     <= '0;
      last_q  <= 1'b0;
      r_q     <= 1'b0;
      upg_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      last_q  <= last_d;
      r_q     <= r_d;
      upg_q   <= upg_d;
      wr_q    <= wr_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    last_d      = last_q;
    r_d         = r_q;
    upg_d       = upg_q;
    wr_d        = wr_q;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IDLE: state_d = |req ? ARB : IDLE;
      ARB: begin
        r_d     = pick;
        a_d     = daddr[pick];
        upg_d   = up[pick];
        wr_d    = ccwrite[pick];
        state_d = !(|req) ? IDLE : wb[pick] ? DWB : SNOOP;
      end
      SNOOP: begin
        ccwait[p]      = 1'b1;
        ccsnoopaddr[p] = a_q;
        ccinv[p]       = upg_q | wr_q;
        if (cctrans[p]) state_d = ccwrite[p] ? PEERWB1 : upg_q ? UPG : LD1;
      end
      PEERWB1, PEERWB2: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[p];
        ramstore = dstore[p];
        dwait[p] = ~ram_ack;
`ifdef SNOOP_FORWARD_EN
        if (!upg_q) begin
          dload[r_q] = dstore[p];
          dwait[r_q] = ~ram_ack;
        end
        if (ram_ack) state_d = (state_q == PEERWB1) ? PEERWB2 : upg_q ? UPG : IDLE;
`else
        if (ram_ack) state_d = (state_q == PEERWB1) ? PEERWB2 : upg_q ? UPG : LD1;
`endif
      end
      LD1, LD2: begin
        ramREN     = 1'b1;
        ramaddr    = {a_q[31:3], state_q == LD2, 2'b00};
        dload[r_q] = ramload;
        dwait[r_q] = ~ram_ack;
        ccinv[r_q] = 1'b1;
        if (ram_ack) state_d = (state_q == LD1) ? LD2 : IDLE;
      end
      UPG: begin
        ccinv[r_q] = 1'b1;
        dwait[r_q] = 1'b0;
        state_d    = IDLE;
      end
      DWB: begin
        ramWEN     = 1'b1;
        ramaddr    = daddr[r_q];
        ramstore   = dstore[r_q];
        dwait[r_q] = ~ram_ack;
        if (ram_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE && state_q != IDLE && state_q != ARB) last_d = ~r_q;
  end
endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// tb_bus_coherence_ctrl: directed scoreboard bench for bus_coherence_ctrl.
module tb_bus_coherence_ctrl;
  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       dREN = '0, dWEN = '0, cctrans = '0, ccwrite = '0;
  logic [1:0][31:0] daddr = '0, dstore = '0;
  logic [1:0]       dwait, ccwait, ccinv;
  logic [1:0][31:0] dload, ccsnoopaddr;
  logic             ramREN, ramWEN, ram_ack;
  logic [31:0]      ramaddr, ramstore, ramload;
  typedef struct packed {
    logic        ren, wen;
    logic [31:0] raddr, rstore;
    logic [1:0]  dw;
    logic [31:0] dl0, dl1;
    logic [1:0]  cw, ci;
    logic [31:0] sa0, sa1;
  } obs_t;
  obs_t exp_q[$];
  int n_cmp = 0, n_fail = 0;
`ifdef SNOOP_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  bus_coherence_ctrl dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
    .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ack(ram_ack)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  assign ramload = mem(ramaddr);
  function automatic obs_t snap();
    obs_t o;
    o.ren = ramREN; o.wen = ramWEN; o.raddr = ramaddr; o.rstore = ramstore; o.dw = dwait;
    o.dl0 = dload[0]; o.dl1 = dload[1]; o.cw = ccwait; o.ci = ccinv;
    o.sa0 = ccsnoopaddr[0]; o.sa1 = ccsnoopaddr[1];
    return o;
  endfunction
  function automatic obs_t dflt();
    obs_t o = '0;
    o.dw = 2'b11;
    return o;
  endfunction
  task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push_snoop(input bit pc, input logic [31:0] a, input bit inv);
    obs_t o = dflt();
    o.cw[pc] = 1'b1;
    o.ci[pc] = inv;
    if (pc) o.sa1 = a; else o.sa0 = a;
    exp_q.push_back(o);
  endtask
  task automatic push_ld(input bit rc, input logic [31:0] a);
    obs_t o = dflt();
    o.ren = 1'b1; o.raddr = a; o.dw[rc] = 1'b0; o.ci[rc] = 1'b1;
    if (rc) o.dl1 = mem(a); else o.dl0 = mem(a);
    exp_q.push_back(o);
  endtask
  task automatic push_pwb(input bit pc, input logic [31:0] a, input logic [31:0] d, input bit fwd);
    obs_t o = dflt();
    o.wen = 1'b1; o.raddr = a; o.rstore = d; o.dw[pc] = 1'b0;
    if (fwd) begin
      o.dw[~pc] = 1'b0;
      if (pc) o.dl0 = d; else o.dl1 = d;
    end
    exp_q.push_back(o);
  endtask
  task automatic push_upg(input bit rc);
    obs_t o = dflt();
    o.ci[rc] = 1'b1; o.dw[rc] = 1'b0;
    exp_q.push_back(o);
  endtask
  task automatic push_dwb(input bit rc, input logic [31:0] a, input logic [31:0] d);
    obs_t o = dflt();
    o.wen = 1'b1; o.raddr = a; o.rstore = d; o.dw[rc] = 1'b0;
    exp_q.push_back(o);
  endtask
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask
  task automatic wait_snp(input bit pc);
    for (int i = 0; i < 20; i++) begin
      if (ccwait[pc]) return;
      tick();
    end
    n_cmp++; n_fail++;
    $display("FAIL snoop_timeout: ccwait[%0d] got 0 expected 1 within 20 cycles", pc);
  endtask
  task automatic wait_ack(input bit c);
    for (int i = 0; i < 20; i++) begin
      if (!dwait[c]) return;
      tick();
    end
    n_cmp++; n_fail++;
    $display("FAIL ack_timeout: dwait[%0d] got 1 expected 0 within 20 cycles", c);
  endtask
  // Monitor: every cycle the DUT presents a response it is popped against the scoreboard
  always @(negedge CLK) begin
    if (nRST && (((ramREN | ramWEN) & ram_ack) || (|ccwait) || dwait != 2'b11)) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_event: got %h expected no response", snap());
      end else check_obs("event", snap(), exp_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation got past 100000 time units expected earlier finish");
    $fatal(1, "watchdog");
  end
  initial begin
    nRST = 1'b0;
    ram_ack = 1'b1;
    #1 check_obs("reset_outputs", snap(), dflt());
    #20;
    tick();
    nRST = 1'b1;
    tick();
    // core0 read-miss 0x40, peer clean
    push_snoop(1, 32'h40, 1'b0);
    push_ld(0, 32'h40);
    push_ld(0, 32'h44);
    daddr[0] = 32'h40; dREN[0] = 1'b1; cctrans[0] = 1'b1;
    wait_snp(1);
    cctrans[1] = 1'b1;
    tick();
    cctrans[1] = 1'b0;
    tick();
    dREN[0] = 1'b0; cctrans[0] = 1'b0;
    tick();
    // core1 upgrade 0x80, peer clean
    push_snoop(0, 32'h80, 1'b1);
    push_upg(1);
    daddr[1] = 32'h80; cctrans[1] = 1'b1; ccwrite[1] = 1'b1;
    wait_snp(0);
    cctrans[0] = 1'b1;
    tick();
    cctrans = '0; ccwrite = '0;
    tick();
    // core0 read 0x100, core1 holds it dirty
    push_snoop(1, 32'h100, 1'b0);
    push_pwb(1, 32'h100, 32'hDEAD_0001, FWD);
    push_pwb(1, 32'h104, 32'hDEAD_0002, FWD);
    if (!FWD) begin
      push_ld(0, 32'h100);
      push_ld(0, 32'h104);
    end
    daddr[0] = 32'h100; dREN[0] = 1'b1; cctrans[0] = 1'b1;
    daddr[1] = 32'h100; dstore[1] = 32'hDEAD_0001;
    wait_snp(1);
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1;
    tick();
    daddr[1] = 32'h104; dstore[1] = 32'hDEAD_0002;
    tick();
    cctrans[1] = 1'b0; ccwrite[1] = 1'b0;
    if (!FWD) begin
      tick();
      tick();
    end
    dREN[0] = 1'b0; cctrans[0] = 1'b0;
    tick();
    // fresh reset, then tied plain writebacks alternate starting with core0
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    push_dwb(0, 32'h200, 32'h0000_0A00);
    push_dwb(1, 32'h300, 32'h0000_0B00);
    push_dwb(0, 32'h204, 32'h0000_0A04);
    push_dwb(1, 32'h304, 32'h0000_0B04);
    daddr[0] = 32'h200; dstore[0] = 32'h0000_0A00; dWEN[0] = 1'b1;
    daddr[1] = 32'h300; dstore[1] = 32'h0000_0B00; dWEN[1] = 1'b1;
    wait_ack(0);
    daddr[0] = 32'h204; dstore[0] = 32'h0000_0A04;
    tick();
    wait_ack(1);
    daddr[1] = 32'h304; dstore[1] = 32'h0000_0B04;
    tick();
    wait_ack(0);
    dWEN[0] = 1'b0;
    tick();
    wait_ack(1);
    dWEN[1] = 1'b0;
    tick();
    // reset asserted while LD1 waits on RAM
    push_snoop(1, 32'h40, 1'b0);
    ram_ack = 1'b0;
    daddr[0] = 32'h40; dREN[0] = 1'b1; cctrans[0] = 1'b1;
    wait_snp(1);
    cctrans[1] = 1'b1;
    tick();
    check32("ld1_ramREN", {31'b0, ramREN}, 32'd1);
    check32("ld1_addr", ramaddr, 32'h40);
    nRST = 1'b0;
    #1 check_obs("reset_async", snap(), dflt());
    dREN = '0; cctrans = '0;
    @(posedge CLK);
    #1 check32("reset_no_ram", {30'b0, ramREN, ramWEN}, 32'd0);
    ram_ack = 1'b1;
    tick();
    nRST = 1'b1;
    tick();
    push_dwb(1, 32'h400, 32'h1234_5678);
    daddr[1] = 32'h400; dstore[1] = 32'h1234_5678; dWEN[1] = 1'b1;
    wait_ack(1);
    dWEN[1] = 1'b0;
    repeat (3) tick();
    check32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
